// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one product/quotient bit per cycle,
// fixed latency of XLEN+1 cycles from accept to the done pulse.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic [4:0]        dest_q, dest_d, rdo_q, rdo_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              signA, signB;
  logic [XLEN-1:0]   magA, magB;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodS;
  logic [XLEN-1:0]   quoS, remS, finalRes;

  // Operand conditioning and the per-cycle shift-add / shift-subtract step.
  // The work register holds {accumulator, multiplier} or {remainder, quotient}.
  always_comb begin
    signA    = rs1_val[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                  funct3 == 3'b100 || funct3 == 3'b110);
    signB    = rs2_val[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 ||
                                  funct3 == 3'b110);
    magA     = signA ? -rs1_val : rs1_val;
    magB     = signB ? -rs2_val : rs2_val;
    mulSum   = {1'b0, work_q[2*XLEN-1:XLEN]} +
               {1'b0, (work_q[0] ? opb_q : {XLEN{1'b0}})};
    divShift = work_q[2*XLEN-1:XLEN-1];
    divDiff  = divShift - {1'b0, opb_q};
    prodS    = negq_q ? -work_q : work_q;
    quoS     = negq_q ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    remS     = negr_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    finalRes = '0;
    case (op_q)
      3'b000:                 finalRes = prodS[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalRes = prodS[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalRes = dz_q ? {XLEN{1'b1}} : quoS;
      default:                finalRes = remS;
    endcase
  end

  // Divide-by-zero only needs the quotient override; the remainder path
  // naturally reproduces the dividend, and signed overflow falls out correctly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opb_d   = opb_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    dest_d  = dest_q;
    rdo_d   = rdo_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = funct3[2] ? DIV : MUL;
          cnt_d   = '0;
          work_d  = {{XLEN{1'b0}}, (funct3[2] ? magA : magB)};
          opb_d   = funct3[2] ? magB : magA;
          op_d    = funct3;
          negq_d  = signA ^ signB;
          negr_d  = signA;
          dz_d    = (rs2_val == '0);
          dest_d  = rd_in;
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        if (cnt_q == CW'(XLEN)) begin
          state_d = DONE;
          res_d   = finalRes;
          rdo_d   = dest_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == MUL)
            work_d = {mulSum, work_q[XLEN-1:1]};
          else if (divDiff[XLEN])
            work_d = {divShift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
          else
            work_d = {divDiff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      dest_q  <= '0;
      rdo_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      dest_q  <= dest_d;
      rdo_q   <= rdo_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign rd_out    = rdo_q;
  assign reg_write = done && (rdo_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result values, fixed latency,
// handshake corner cases and asynchronous abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [63:0] rs1Val, rs2Val;
  logic [4:0]  rdIn;
  logic        busy, done, regWrite;
  logic [63:0] result;
  logic [4:0]  rdOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[20];

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_val(rs1Val), .rs2_val(rs2Val), .rd_in(rdIn),
    .busy(busy), .done(done), .result(result), .rd_out(rdOut),
    .reg_write(regWrite)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives a request for one edge, then scrambles the operand inputs.
  task automatic applyStimulus(input logic [2:0] f, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd);
    start = 1'b1; funct3 = f; rs1Val = a; rs2Val = b; rdIn = rd;
    @(posedge clk); #1;
    start = 1'b0;
    rs1Val = 64'hDEAD_BEEF_0BAD_F00D; rs2Val = 64'h1234_5678_9ABC_DEF0;
    rdIn = 5'd31; funct3 = 3'b111;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int doneSeen;

  initial begin
    vecs[0]  = '{3'b000, 64'd5, 64'd10, 5'd3, 64'd50, "mul_5x10"};
    vecs[1]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, "mulh_m2x3"};
    vecs[2]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1, "mulhu_max_x2"};
    vecs[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1x2"};
    vecs[4]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFA, "div_m20_3"};
    vecs[5]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, "rem_m20_3"};
    vecs[6]  = '{3'b101, 64'd20, 64'd3, 5'd9, 64'd6, "divu_20_3"};
    vecs[7]  = '{3'b111, 64'd20, 64'd3, 5'd10, 64'd2, "remu_20_3"};
    vecs[8]  = '{3'b100, 64'd20, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, "div_by0"};
    vecs[9]  = '{3'b110, 64'd20, 64'd0, 5'd12, 64'd20, "rem_by0"};
    vecs[10] = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'h8000_0000_0000_0000, "div_ovf"};
    vecs[11] = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'd0, "rem_ovf"};
    vecs[12] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd1, "mul_max_lo"};
    vecs[13] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_max"};
    vecs[14] = '{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd17, 64'h4000_0000_0000_0000, "mulh_minsq"};
    vecs[15] = '{3'b101, 64'd77, 64'd0, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0"};
    vecs[16] = '{3'b111, 64'd77, 64'd0, 5'd19, 64'd77, "remu_by0"};
    vecs[17] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd20, 64'hFFFF_FFFF_FFFF_FFFD, "div_7_m2"};
    vecs[18] = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd21, 64'd1, "rem_7_m2"};
    vecs[19] = '{3'b000, 64'd6, 64'd7, 5'd0, 64'd42, "mul_rd0"};

    reset = 1'b1; start = 1'b0; funct3 = '0; rs1Val = '0; rs2Val = '0; rdIn = '0;
    #12;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_regwrite", {63'd0, regWrite}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_rdout", {59'd0, rdOut}, 64'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      checkOutput({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd1);
      waitDone(lat);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'd65);
      checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp);
      checkOutput({vecs[i].name, "_rdout"}, {59'd0, rdOut}, {59'd0, vecs[i].rd});
      checkOutput({vecs[i].name, "_regwrite"}, {63'd0, regWrite}, {63'd0, (vecs[i].rd != 5'd0)});
      checkOutput({vecs[i].name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
      checkOutput({vecs[i].name, "_hold"}, result, vecs[i].exp);
    end

    // Requests while busy must not disturb the operation in flight.
    @(negedge clk);
    applyStimulus(3'b000, 64'd5, 64'd10, 5'd3);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; funct3 = 3'b101; rs1Val = 64'd100; rs2Val = 64'd7; rdIn = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("ignored_latency", 64'(lat + 13), 64'd65);
    checkOutput("ignored_result", result, 64'd50);
    checkOutput("ignored_rdout", {59'd0, rdOut}, 64'd3);

    // Back-to-back: a request in the DONE cycle is accepted directly.
    @(negedge clk);
    applyStimulus(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5);
    waitDone(lat);
    checkOutput("b2b_first_result", result, 64'd1);
    applyStimulus(3'b101, 64'd100, 64'd7, 5'd7);
    checkOutput("b2b_second_busy", {63'd0, busy}, 64'd1);
    waitDone(lat);
    checkOutput("b2b_second_latency", 64'(lat), 64'd65);
    checkOutput("b2b_second_result", result, 64'd14);
    checkOutput("b2b_second_rdout", {59'd0, rdOut}, 64'd7);

    // Asynchronous reset partway through an operation aborts it.
    @(negedge clk);
    applyStimulus(3'b000, 64'd5, 64'd10, 5'd3);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_regwrite", {63'd0, regWrite}, 64'd0);
    checkOutput("abort_result", result, 64'd0);
    checkOutput("abort_rdout", {59'd0, rdOut}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    @(negedge clk);
    applyStimulus(3'b000, 64'd4, 64'd4, 5'd2);
    waitDone(lat);
    checkOutput("post_reset_latency", 64'(lat), 64'd65);
    checkOutput("post_reset_result", result, 64'd16);
    checkOutput("post_reset_regwrite", {63'd0, regWrite}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execute unit.
- Consumes read_data1/read_data2 from the register file and produces the write-back value, destination register and write strobe that drive the register file's write_data/rd/RegWrite.
- Fixed multi-cycle latency, with a start/busy/done handshake toward the sequential control unit.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; returns unit to IDLE
start  input  1  request; sampled on rising edge when busy=0
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A (dividend / multiplicand)
rs2_val  input  XLEN  operand B (divisor / multiplier)
rd_in  input  5  destination register index
busy  output  1  high while an operation is iterating
done  output  1  one-cycle pulse: result valid
result  output  XLEN  registered result; holds until next done
rd_out  output  5  destination index, registered with result
reg_write  output  1  write strobe to register file; equals done AND (rd_out != 0)

Behaviour:
- Reset: asynchronous, active-high, on clk.
  - While reset is high: state=IDLE; busy, done, reg_write, result and rd_out are all 0; iteration counter = 0.
  - Reset mid-operation aborts the operation; no done and no reg_write for it.
- States: IDLE, MUL, DIV, DONE.
- Accept:
  - In IDLE or DONE, start=1 at edge E0 latches funct3, rd_in, operand magnitudes and sign flags.
  - Next state is MUL (funct3[2]=0) or DIV (funct3[2]=1); busy=1 from E0.
- Ignored requests: start while busy=1 is ignored and has no effect on the operation in flight.
- Iteration:
  - Exactly XLEN edges (E1..E64) in MUL/DIV, one bit per edge.
  - MUL: shift-add over 2*XLEN product.
  - DIV: restoring shift-subtract producing quotient and remainder.
- Completion:
  - At edge E65, state goes to DONE and result, rd_out are registered.
  - done=1 and busy=0 for exactly one cycle, the cycle after E65.
  - Fixed latency is 65 cycles from accept edge to done, for every op including special cases.
- DONE exit:
  - DONE goes to IDLE at the next edge.
  - If start=1 in DONE, that request is accepted (back-to-back).
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Signed operands are converted to magnitudes; the sign is reapplied after the last iteration.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the correctly signed 2*XLEN product.
  - DIV/DIVU: quotient, truncated toward zero.
  - REM/REMU: remainder, with the sign of the dividend.
- Divide by zero (divisor=0):
  - quotient = all ones (-1 for DIV, 2^XLEN-1 for DIVU).
  - remainder = dividend.
- Signed overflow (DIV/REM, dividend = -2^(XLEN-1), divisor = -1):
  - quotient = -2^(XLEN-1).
  - remainder = 0.
- Register x0: rd_in=0 completes normally (done pulses, result updated) but reg_write stays 0.
- Hold: result and rd_out are stable from done until the next done or reset; operand inputs need not be held after accept.

Test Plan:
- Reset, then MUL with rs1=5, rs2=10, rd=3 → done exactly 65 cycles after the accept edge; result=50; rd_out=3; reg_write=1 for one cycle; busy high for 65 cycles.
- MULH with rs1=-2 (0xFFFF_FFFF_FFFF_FFFE), rs2=3 → result=0xFFFF_FFFF_FFFF_FFFF; MULHU with 0xFFFF_FFFF_FFFF_FFFF × 2 → result=1; MULHSU with rs1=-1, rs2=2 → result=0xFFFF_FFFF_FFFF_FFFF.
- DIV -20/3 → quotient -6; REM -20/3 → remainder -2; DIVU 20/3 → 6; REMU 20/3 → 2.
- Edge cases:
  - DIV 20/0 → 0xFFFF_FFFF_FFFF_FFFF; REM 20/0 → 20.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM of the same → 0.
  - All complete at the 65-cycle latency.
- Back-to-back and ignored start:
  - start asserted during busy (different operands) → ignored, first result unaffected.
  - start asserted in the DONE cycle → second op accepted, with its done exactly 65 cycles later.
  - rd_in=0 → done=1, reg_write=0.
- Reset asserted at iteration 30 → busy/done/reg_write drop immediately, result=0, no done pulse afterwards; a new MUL 4×4 after reset release → result 16.
